axi_sram_slave: RTL



---
 rtl/axi_pkg.sv | 34 +++
 rtl/axi_slave_mem.sv | 29 ++
 rtl/axi_sram_slave.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared AXI definitions for the SRAM slave: burst/response codes, FSM
// encodings and the per-beat address step.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_WAIT = 2'd1,
        RD_DATA = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_DATA = 2'd1,
        WR_RESP = 2'd2
    } wr_state_t;

    // WRAP bursts step like INCR; only FIXED holds the address.
    function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                              input logic [2:0]  size,
                                              input logic [1:0]  burst);
        if (burst == BURST_FIXED) begin
            return addr;
        end
        return addr + (32'd1 << size);
    endfunction

endpackage

// File: rtl/axi_slave_mem.sv
// Word-addressed 32-bit RAM: byte-strobed synchronous write, asynchronous read.
// Contents are deliberately not reset.
module axi_slave_mem #(
    parameter int ADDR_W = 14
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [31:0]       i_wdata,
    input  logic [3:0]        i_wstrb,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [31:0]       o_rdata
);

    logic [31:0] r_mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int i = 0; i < 4; i++) begin
                if (i_wstrb[i]) begin
                    r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 SRAM slave with independent read and write paths, FIXED/INCR bursts
// and a fixed idle latency between AR handshake and first read beat.
//
// state   | meaning
// RD_IDLE | arready high, waiting for a read request
// RD_WAIT | counting down the read latency
// RD_DATA | presenting read beats until the rlast handshake
// WR_IDLE | awready high, W channel stalled
// WR_DATA | accepting write beats until wlast
// WR_RESP | holding the B response until bready
module axi_sram_slave
    import axi_pkg::*;
#(
    parameter int ADDR_W   = 14,
    parameter int RD_DELAY = 2
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic [1:0]  arlock,
    input  logic [3:0]  arcache,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [1:0]  awlock,
    input  logic [3:0]  awcache,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam logic [3:0] DLY = 4'(RD_DELAY);

    rd_state_t   r_rd_st, w_rd_st_nxt;
    wr_state_t   r_wr_st, w_wr_st_nxt;
    logic        r_rst_done;

    logic [3:0]  r_arid;
    logic [31:0] r_raddr;
    logic [7:0]  r_arlen;
    logic [2:0]  r_arsize;
    logic [1:0]  r_arburst;
    logic [7:0]  r_rbeat;
    logic [3:0]  r_rdly;

    logic [3:0]  r_awid;
    logic [31:0] r_waddr;
    logic [7:0]  r_awlen;
    logic [2:0]  r_awsize;
    logic [1:0]  r_awburst;
    logic [7:0]  r_wbeat;
    logic        r_werr;
    logic [1:0]  r_bresp;

    logic        w_ar_hs, w_r_hs, w_aw_hs, w_w_hs, w_beat_err, w_unused;

    // Handshake readiness is held off until the first clock after reset.
    assign arready = r_rst_done && (r_rd_st == RD_IDLE);
    assign rvalid  = (r_rd_st == RD_DATA);
    assign rlast   = rvalid && (r_rbeat == r_arlen);
    assign rid     = r_arid;
    assign rresp   = RESP_OKAY;
    assign awready = r_rst_done && (r_wr_st == WR_IDLE);
    assign wready  = (r_wr_st == WR_DATA);
    assign bvalid  = (r_wr_st == WR_RESP);
    assign bid     = r_awid;
    assign bresp   = r_bresp;

    assign w_ar_hs = arvalid && arready;
    assign w_r_hs  = rvalid && rready;
    assign w_aw_hs = awvalid && awready;
    assign w_w_hs  = wvalid && wready;
    assign w_beat_err = wlast ? (r_wbeat != r_awlen) : (r_wbeat == r_awlen);

    assign w_unused = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid,
                        r_raddr[31:ADDR_W+2], r_raddr[1:0],
                        r_waddr[31:ADDR_W+2], r_waddr[1:0], BURST_INCR, BURST_WRAP};

    always_comb begin
        w_rd_st_nxt = r_rd_st;
        case (r_rd_st)
            RD_IDLE: if (w_ar_hs) w_rd_st_nxt = (RD_DELAY == 0) ? RD_DATA : RD_WAIT;
            RD_WAIT: if (r_rdly == 4'd1) w_rd_st_nxt = RD_DATA;
            RD_DATA: if (w_r_hs && rlast) w_rd_st_nxt = RD_IDLE;
            default: w_rd_st_nxt = RD_IDLE;
        endcase
    end

    always_comb begin
        w_wr_st_nxt = r_wr_st;
        case (r_wr_st)
            WR_IDLE: if (w_aw_hs) w_wr_st_nxt = WR_DATA;
            WR_DATA: if (w_w_hs && wlast) w_wr_st_nxt = WR_RESP;
            WR_RESP: if (bready) w_wr_st_nxt = WR_IDLE;
            default: w_wr_st_nxt = WR_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rst_done <= 1'b0;
            r_rd_st    <= RD_IDLE;
            r_arid     <= '0;
            r_raddr    <= '0;
            r_arlen    <= '0;
            r_arsize   <= '0;
            r_arburst  <= '0;
            r_rbeat    <= '0;
            r_rdly     <= '0;
        end else begin
            r_rst_done <= 1'b1;
            r_rd_st    <= w_rd_st_nxt;
            if (w_ar_hs) begin
                r_arid    <= arid;
                r_raddr   <= araddr;
                r_arlen   <= arlen;
                r_arsize  <= arsize;
                r_arburst <= arburst;
                r_rbeat   <= '0;
                r_rdly    <= DLY;
            end
            if (r_rd_st == RD_WAIT) begin
                r_rdly <= r_rdly - 4'd1;
            end
            if (w_r_hs) begin
                r_raddr <= next_addr(r_raddr, r_arsize, r_arburst);
                r_rbeat <= r_rbeat + 8'd1;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wr_st   <= WR_IDLE;
            r_awid    <= '0;
            r_waddr   <= '0;
            r_awlen   <= '0;
            r_awsize  <= '0;
            r_awburst <= '0;
            r_wbeat   <= '0;
            r_werr    <= 1'b0;
            r_bresp   <= RESP_OKAY;
        end else begin
            r_wr_st <= w_wr_st_nxt;
            if (w_aw_hs) begin
                r_awid    <= awid;
                r_waddr   <= awaddr;
                r_awlen   <= awlen;
                r_awsize  <= awsize;
                r_awburst <= awburst;
                r_wbeat   <= '0;
                r_werr    <= 1'b0;
            end
            if (w_w_hs) begin
                r_waddr <= next_addr(r_waddr, r_awsize, r_awburst);
                r_wbeat <= r_wbeat + 8'd1;
                r_werr  <= r_werr | w_beat_err;
                if (wlast) begin
                    r_bresp <= (r_werr | w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                end
            end
        end
    end

    axi_slave_mem #(.ADDR_W(ADDR_W)) u_mem (
        .i_clk   (aclk),
        .i_we    (w_w_hs),
        .i_waddr (r_waddr[ADDR_W+1:2]),
        .i_wdata (wdata),
        .i_wstrb (wstrb),
        .i_raddr (r_raddr[ADDR_W+1:2]),
        .o_rdata (rdata)
    );

endmodule
